// File: rtl/display_compositor.sv
// rtl/display_compositor.sv - VGA timing generator with frame-synchronous source selection and fades
// Geometry parameters default to 640x480@60; smaller values give a reduced raster with identical behaviour.
module display_compositor #(
    parameter int N_SRC       = 3,
    parameter int SEL_W       = 2,
    parameter int CLK_DIV     = 4,
    parameter int FADE_FRAMES = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      src_sel,
    input  logic                  fade_en,
    input  logic [N_SRC*12-1:0]   src_rgb,
    output logic                  pix_ce,
    output logic [9:0]            x_cnt,
    output logic [9:0]            y_cnt,
    output logic                  valid,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            vgaRed,
    output logic [3:0]            vgaGreen,
    output logic [3:0]            vgaBlue,
    output logic                  busy
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int STEP_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FADE_FRAMES - 1);
    localparam logic [9:0]        H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]        H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]        H_SYNC_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]        H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]        V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]        V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]        V_SYNC_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]        V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [4:0]        LEVEL_MAX  = 5'd16;

    typedef enum logic [1:0] {
        S_SHOW,
        S_FADE_OUT,
        S_FADE_IN
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic [11:0]         rgb_q, rgb_d;
    logic [4:0]          level_q, level_d;
    logic [SEL_W-1:0]    active_q, active_d;
    logic [SEL_W-1:0]    target_q, target_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic                line_end;
    logic                frame_end;
    logic                pix_valid;
    logic [11:0]         src_px;
    logic [SEL_W-1:0]    tgt_new;

    function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] lvl);
        logic [7:0] prod;
        prod = {4'b0, c} * {3'b0, lvl};
        return 4'(prod >> 4);
    endfunction

    assign pix_ce    = (div_q == DIV_LAST);
    assign line_end  = (x_q == H_LAST);
    assign frame_end = pix_ce && line_end && (y_q == V_LAST);
    assign pix_valid = (x_q < H_VIS) && (y_q < V_VIS);

    // Out-of-range requests leave the previous target in place.
    assign tgt_new = (32'(src_sel) < 32'(N_SRC)) ? src_sel : target_q;

    always_comb begin
        src_px = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (active_q == SEL_W'(k)) begin
                src_px = src_rgb[k*12 +: 12];
            end
        end
    end

    always_comb begin
        div_d = pix_ce ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (pix_ce) begin
            x_d = line_end ? 10'd0 : x_q + 10'd1;
            if (line_end) begin
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end
            // Registered from the current counters, so these lag x_cnt/y_cnt by one pixel.
            hs_d  = !((x_q >= H_SYNC_LO) && (x_q < H_SYNC_HI));
            vs_d  = !((y_q >= V_SYNC_LO) && (y_q < V_SYNC_HI));
            rgb_d = pix_valid ? {scale_chan(src_px[11:8], level_q),
                                 scale_chan(src_px[7:4],  level_q),
                                 scale_chan(src_px[3:0],  level_q)} : 12'h000;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        active_d = active_q;
        target_d = target_q;
        step_d   = step_q;
        if (frame_end) begin
            target_d = tgt_new;
            case (state_q)
                S_SHOW: begin
                    if (tgt_new != active_q) begin
                        if (fade_en) begin
                            state_d = S_FADE_OUT;
                            step_d  = '0;
                        end else begin
                            active_d = tgt_new;
                        end
                    end
                end
                S_FADE_OUT: begin
                    if (!fade_en) begin
                        active_d = tgt_new;
                        level_d  = LEVEL_MAX;
                        state_d  = S_SHOW;
                        step_d   = '0;
                    end else if (level_q == 5'd0) begin
                        // Redirected from FADE_IN while already black: swap immediately.
                        active_d = tgt_new;
                        state_d  = S_FADE_IN;
                        step_d   = '0;
                    end else if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            active_d = tgt_new;
                            state_d  = S_FADE_IN;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_FADE_IN: begin
                    if (!fade_en) begin
                        active_d = tgt_new;
                        level_d  = LEVEL_MAX;
                        state_d  = S_SHOW;
                        step_d   = '0;
                    end else if (tgt_new != active_q) begin
                        state_d = S_FADE_OUT;
                        step_d  = '0;
                    end else if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == LEVEL_MAX - 5'd1) begin
                            state_d = S_SHOW;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_SHOW;
                    level_d = LEVEL_MAX;
                    step_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_SHOW;
            div_q    <= '0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= 12'h000;
            level_q  <= LEVEL_MAX;
            active_q <= '0;
            target_q <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            rgb_q    <= rgb_d;
            level_q  <= level_d;
            active_q <= active_d;
            target_q <= target_d;
            step_q   <= step_d;
        end
    end

    assign x_cnt    = x_q;
    assign y_cnt    = y_q;
    assign valid    = pix_valid;
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign vgaRed   = rgb_q[11:8];
    assign vgaGreen = rgb_q[7:4];
    assign vgaBlue  = rgb_q[3:0];
    assign busy     = (state_q != S_SHOW);

endmodule

// File: tb/tb_display_compositor.sv
// tb/tb_display_compositor.sv - reduced-raster bench for display_compositor against a frame-level reference model
module tb_display_compositor;

    localparam int N_SRC = 3;
    localparam int SEL_W = 2;
    localparam int CLK_DIV = 4;
    localparam int FADE_FRAMES = 1;
    localparam int HV = 8, HF = 1, HSY = 2, HB = 1;
    localparam int VV = 6, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME_CLK = HT * VT * CLK_DIV;

    logic                clk = 1'b0;
    logic                rst;
    logic [SEL_W-1:0]    src_sel;
    logic                fade_en;
    logic [N_SRC*12-1:0] src_rgb;
    logic                pix_ce;
    logic [9:0]          x_cnt, y_cnt;
    logic                valid, hsync, vsync, busy;
    logic [3:0]          vgaRed, vgaGreen, vgaBlue;

    display_compositor #(
        .N_SRC(N_SRC), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .FADE_FRAMES(FADE_FRAMES),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .src_sel(src_sel), .fade_en(fade_en), .src_rgb(src_rgb),
        .pix_ce(pix_ce), .x_cnt(x_cnt), .y_cnt(y_cnt), .valid(valid),
        .hsync(hsync), .vsync(vsync), .vgaRed(vgaRed), .vgaGreen(vgaGreen),
        .vgaBlue(vgaBlue), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic chk_on = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: raster position is pure arithmetic on edges since reset;
    // screen state (level, shown source, target, fade direction) changes only at frame ends.
    int k;
    int lvl, act, tgt, mode, cnt;   // mode: 0 steady, 1 fading out, 2 fading in
    logic        e_hs, e_vs;
    logic [11:0] e_rgb;

    function automatic int scale(input int c, input int l);
        return (c * l) / 16;
    endfunction

    task automatic model_reset();
        k = 0; lvl = 16; act = 0; tgt = 0; mode = 0; cnt = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
    endtask

    task automatic frame_update();
        if (int'(src_sel) < N_SRC) tgt = int'(src_sel);
        if (mode == 0) begin
            if (tgt != act) begin
                if (fade_en) begin mode = 1; cnt = 0; end
                else act = tgt;
            end
        end else if (!fade_en) begin
            act = tgt; lvl = 16; mode = 0; cnt = 0;
        end else if (mode == 1) begin
            if (lvl == 0) begin
                act = tgt; mode = 2; cnt = 0;
            end else begin
                cnt++;
                if (cnt == FADE_FRAMES) begin
                    cnt = 0; lvl--;
                    if (lvl == 0) begin act = tgt; mode = 2; end
                end
            end
        end else begin
            if (tgt != act) begin
                mode = 1; cnt = 0;
            end else begin
                cnt++;
                if (cnt == FADE_FRAMES) begin
                    cnt = 0; lvl++;
                    if (lvl == 16) mode = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                k = k + 1;
                if (k % CLK_DIV == 0) begin
                    int q, px, py;
                    logic [11:0] s;
                    q  = k / CLK_DIV - 1;
                    px = q % HT;
                    py = (q / HT) % VT;
                    e_hs = !(px >= HV + HF && px < HV + HF + HSY);
                    e_vs = !(py >= VV + VF && py < VV + VF + VSY);
                    s = src_rgb[act*12 +: 12];
                    if (px < HV && py < VV)
                        e_rgb = {4'(scale(int'(s[11:8]), lvl)), 4'(scale(int'(s[7:4]), lvl)),
                                 4'(scale(int'(s[3:0]), lvl))};
                    else
                        e_rgb = 12'h000;
                    if (px == HT - 1 && py == VT - 1) frame_update();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                int p, ex, ey;
                logic epce, evalid;
                p  = k / CLK_DIV;
                ex = p % HT;
                ey = (p / HT) % VT;
                epce   = ((k % CLK_DIV) == CLK_DIV - 1);
                evalid = (ex < HV) && (ey < VV);
                check_eq("pixel",
                    {27'b0, pix_ce, x_cnt, y_cnt, valid, hsync, vsync, vgaRed, vgaGreen, vgaBlue, busy},
                    {27'b0, epce, 10'(ex), 10'(ey), evalid, e_hs, e_vs, e_rgb, (mode != 0)});
            end
        end
    end

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        @(negedge clk);
        while ((k % FRAME_CLK) != ph && n < FRAME_CLK + 4) begin
            @(negedge clk);
            n++;
        end
        if ((k % FRAME_CLK) != ph) check_eq("wait_phase_timeout", 64'(k % FRAME_CLK), 64'(ph));
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME_CLK) @(negedge clk);
    endtask

    function automatic logic [11:0] rgb_now();
        return {vgaRed, vgaGreen, vgaBlue};
    endfunction

    initial begin
        int pce_cnt, hs_low, vs_low;
        rst = 1'b0;
        src_sel = 2'd0;
        fade_en = 1'b0;
        src_rgb = {12'h0F0, 12'hF00, 12'h00F};
        @(negedge clk);
        chk_on = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_pix_ce", 64'(pix_ce), 64'd0);
        check_eq("rst_x", 64'(x_cnt), 64'd0);
        check_eq("rst_y", 64'(y_cnt), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd1);
        check_eq("rst_hsync", 64'(hsync), 64'd1);
        check_eq("rst_vsync", 64'(vsync), 64'd1);
        check_eq("rst_rgb", 64'(rgb_now()), 64'h000);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;

        pce_cnt = 0;
        repeat (40) begin @(negedge clk); if (pix_ce) pce_cnt++; end
        check_eq("pce_cadence", 64'(pce_cnt), 64'(40 / CLK_DIV));

        hs_low = 0; vs_low = 0;
        repeat (2 * FRAME_CLK) begin
            @(negedge clk);
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end
        check_eq("hsync_low_clocks", 64'(hs_low), 64'(2 * VT * HSY * CLK_DIV));
        check_eq("vsync_low_clocks", 64'(vs_low), 64'(2 * VSY * HT * CLK_DIV));

        // Hard cut: change mid-frame, visible only from the next frame.
        wait_phase(100);
        src_sel = 2'd1;
        wait_phase(200);
        check_eq("cut_old_frame", 64'(rgb_now()), 64'h00F);
        check_eq("cut_busy", 64'(busy), 64'd0);
        wait_frames(1);
        check_eq("cut_new_frame", 64'(rgb_now()), 64'hF00);
        check_eq("cut_busy_after", 64'(busy), 64'd0);
        src_sel = 2'd0;
        src_rgb[11:0] = 12'hFFF;
        wait_frames(1);
        check_eq("cut_back", 64'(rgb_now()), 64'hFFF);

        // Full fade 0 -> 1.
        wait_phase(100);
        fade_en = 1'b1;
        src_sel = 2'd1;
        wait_phase(200);
        wait_frames(9);
        check_eq("fade_out_l8", 64'(rgb_now()), 64'h777);
        check_eq("fade_out_busy", 64'(busy), 64'd1);
        wait_frames(8);
        check_eq("fade_l0", 64'(rgb_now()), 64'h000);
        wait_frames(8);
        check_eq("fade_in_l8", 64'(rgb_now()), 64'h700);
        wait_frames(7);
        check_eq("fade_in_l15", 64'(rgb_now()), 64'hE00);
        check_eq("fade_busy_last", 64'(busy), 64'd1);
        wait_frames(1);
        check_eq("fade_done", 64'(rgb_now()), 64'hF00);
        check_eq("fade_done_busy", 64'(busy), 64'd0);

        // Out-of-range request is ignored.
        wait_phase(100);
        src_sel = 2'd3;
        wait_phase(200);
        wait_frames(2);
        check_eq("invalid_sel_rgb", 64'(rgb_now()), 64'hF00);
        check_eq("invalid_sel_busy", 64'(busy), 64'd0);

        // Redirect during fade-in at level 5.
        src_sel = 2'd0;
        wait_frames(22);
        check_eq("fade_in_l5", 64'(rgb_now()), 64'h444);
        src_sel = 2'd2;
        wait_frames(1);
        check_eq("redirect_hold", 64'(rgb_now()), 64'h444);
        check_eq("redirect_busy", 64'(busy), 64'd1);
        wait_frames(1);
        check_eq("redirect_down", 64'(rgb_now()), 64'h333);
        wait_frames(9);
        check_eq("redirect_src2", 64'(rgb_now()), 64'h040);

        // Asynchronous reset in the middle of a fade.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_rgb", 64'(rgb_now()), 64'h000);
        check_eq("midrst_x", 64'(x_cnt), 64'd0);
        check_eq("midrst_sync", 64'({hsync, vsync}), 64'b11);
        @(negedge clk);
        rst = 1'b1;
        wait_phase(200);
        check_eq("midrst_active0", 64'(rgb_now()), 64'hFFF);
        check_eq("midrst_show", 64'(busy), 64'd0);

        // Random selections, fade modes and colours, all scored by the model.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(60, 400)) @(negedge clk);
            src_sel = 2'($urandom_range(0, 3));
            fade_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) src_rgb = 36'({$urandom, $urandom});
        end
        repeat (FRAME_CLK) @(negedge clk);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/display_compositor.md
# display_compositor

Parametrised successor to the Tetris display top. It owns the 640x480@60 VGA timing and selects one of `N_SRC` combinational screen renderers (start, playing, game-over, …) driven by the exported pixel coordinates. Screen changes happen only at frame boundaries, with an optional frame-paced fade-out/fade-in. RGB and sync outputs are registered so that they stay aligned.

## Interface
Parameters:
- `N_SRC`, default 3: number of screen sources, minimum 2.
- `SEL_W`, default 2: width of `src_sel`; must satisfy 2^`SEL_W` >= `N_SRC`.
- `CLK_DIV`, default 4: system clocks per pixel (100 MHz in, 25 MHz pixel rate); must be >= 2.
- `FADE_FRAMES`, default 2: frames per fade step, >= 1.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset, asynchronous and active-low.
- `src_sel`, in, `SEL_W`: requested screen; usually the game state.
- `fade_en`, in, 1: 1 = fade on change, 0 = hard cut.
- `src_rgb`, in, `N_SRC`*12: source k occupies bits [12k+11:12k] as {R,G,B}, 4 bits each.
- `pix_ce`, out, 1: one-clock pixel enable.
- `x_cnt`, out, 10: horizontal pixel counter.
- `y_cnt`, out, 10: vertical line counter.
- `valid`, out, 1: high when `x_cnt` < 640 and `y_cnt` < 480.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `vgaRed`, out, 4: red channel, registered.
- `vgaGreen`, out, 4: green channel, registered.
- `vgaBlue`, out, 4: blue channel, registered.
- `busy`, out, 1: high whenever the state machine is not in SHOW.

## Operation
- **Pixel divider:** the divider counts 0..`CLK_DIV`-1 and wraps. `pix_ce` is high when the count equals `CLK_DIV`-1. All other state advances only on `pix_ce`.
- **Horizontal counter:** `x_cnt` counts 0..799. Visible 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- **Vertical counter:** `y_cnt` increments when `x_cnt` wraps, counting 0..524. Visible 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- **Sources:** sources sample `x_cnt`/`y_cnt` combinationally. On `pix_ce`, the block registers `hsync`, `vsync` and RGB from the current counters, so these outputs lag `x_cnt`/`y_cnt` by exactly one pixel.
- **RGB path:** for each channel, c_out = (c_src[`active`] * `level`) >> 4, where `level` is 5 bits in 0..16 and the product is 9 bits. `level` = 16 passes the colour unchanged. RGB is forced to 0 when the pixel is not valid.
- **Frame boundary (FB):** `pix_ce` with `x_cnt` = 799 and `y_cnt` = 524. `src_sel` is sampled only at FB. Values >= `N_SRC` are ignored, and the previous target is kept.
- **State machine:**
  - **SHOW:** `level` = 16. At FB, if target != `active`:
    - `fade_en` = 0: `active` <= target; stay in SHOW.
    - `fade_en` = 1: go to FADE_OUT.
  - **FADE_OUT:** every `FADE_FRAMES` FBs, `level` decreases by 1. When `level` reaches 0, `active` <= latest valid target and the state goes to FADE_IN.
  - **FADE_IN:** every `FADE_FRAMES` FBs, `level` increases by 1. At 16 the state goes to SHOW. If at any FB the target != `active`, the state goes to FADE_OUT and continues down from the current `level`.
  - **`fade_en` dropped mid-fade:** at the next FB, `active` <= target, `level` = 16, state goes to SHOW.
- **Frame-step counter:** counts FBs 0..`FADE_FRAMES`-1 and clears on every state change.

## Timing
- **Reset values:** divider 0, `x_cnt` 0, `y_cnt` 0, `pix_ce` 0, `valid` 1 (counters at 0,0 are visible), `hsync` 1, `vsync` 1, RGB 0, `level` 16, `active` 0, target 0, state SHOW, `busy` 0.
- **Reset mid-fade:** returns to the reset state at once (asynchronous assertion). Release is taken synchronously at the next `clk`.
- **Line and frame periods:** line = 800*`CLK_DIV` clocks; frame = 420000*`CLK_DIV` clocks.
- **Sync widths:** `hsync` low for 96 pixels; `vsync` low for 2 lines. Sync edges follow the counter values by one pixel.
- **Hard cut:** takes effect on the first pixel of the frame after the FB that sampled the change.
- **Full fade:** 32*`FADE_FRAMES` frames; `busy` is high throughout.

## Test plan
- **Reset:** assert `rst`=0 mid-line with `CLK_DIV`=4 → all outputs at reset values; after release, `pix_ce` high every 4th clock.
- **Sync timing:** run 2 frames → `hsync` low 96 pixels per 800; `vsync` low for lines 490–491; RGB 0 whenever `x_cnt` >= 640 or `y_cnt` >= 480.
- **Hard cut:** `fade_en`=0, src0=0x00F, src1=0xF00, `src_sel` 0→1 mid-frame → current frame stays 0x00F; next frame is 0xF00; `busy` stays 0.
- **Fade:** `fade_en`=1, `FADE_FRAMES`=1, src0=0xFFF, `src_sel`→1 → `level` steps 16..0 over 16 frames (level 8 gives 0x777), `active`=1, then 0..16 over 16 frames; `busy` high for 32 frames.
- **Invalid and mid-fade requests:** `src_sel`=3 with `N_SRC`=3 → ignored. Request source 2 during FADE_IN at `level` 5 → FADE_OUT from 5 → `active`=2.
- **Reset mid-fade:** assert `rst` mid-fade → `level` 16, `active` 0, state SHOW.
